autosel_boot_seq: RTL



---
 rtl/autosel_pkg.sv | 32 +++
 rtl/autosel_delay_cnt.sv | 40 ++++
 rtl/autosel_boot_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/autosel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : autosel_pkg
// Description : Shared types and constants for the tt_autosel boot sequencer.
//               State encoding, START handshake window, magic field bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package autosel_pkg;

    typedef enum logic [2:0] {
        POR     = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CHECK   = 3'd3,
        BACKOFF = 3'd4,
        PUBLISH = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Cycles the reader gets to raise busy after a start request.
    localparam int START_SEEN_LIMIT = 8;

    // Location of the magic nibble inside the EEPROM word.
    localparam int MAGIC_HI = 15;
    localparam int MAGIC_LO = 12;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/autosel_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module      : autosel_delay_cnt
// Description : Shared state timer. Counts cycles since the last clear and
//               flags when the current limit has been reached. The limit is
//               supplied per state by the sequencer.
// Ports       : clk, rst      - clock, async active-high reset
//               i_clear       - restart the count (state entry)
//               i_limit       - cycles to spend before o_expired
//               o_expired     - high on the last cycle of the window
// Revision    : 1.0 - initial release
// ============================================================================
module autosel_delay_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_cnt;

    // Saturates instead of wrapping so a long-lived state never re-expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != {WIDTH{1'b1}}) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    // Expired on the cycle whose count is limit-1, i.e. after i_limit cycles.
    assign o_expired = ({1'b0, r_cnt} + (WIDTH + 1)'(1)) >= {1'b0, i_limit};

endmodule
`default_nettype wire

// File: rtl/autosel_boot_seq.sv
`default_nettype none
// ============================================================================
// Module      : autosel_boot_seq
// Description : Boot-time sequencer for the i2c_eeprom word reader. Holds the
//               reader in reset after power-up, runs read attempts with
//               start/busy timeouts, retries with a reset backoff, validates
//               the magic nibble and publishes the project address over a
//               valid/ready handshake. Falls back to DEFAULT_ADDR on failure.
// Ports       : clk, rst               - clock, async active-high reset
//               o_ee_rst, o_ee_start   - reader reset (registered) and start
//               i_ee_busy, i_ee_error  - reader status (error sticky)
//               i_ee_data              - reader data word
//               i_rerun                - re-read request, honoured in DONE
//               o_sel_addr/valid, i_sel_ready - address handshake
//               o_done, o_fail, o_attempts    - sequence status
// Revision    : 1.0 - initial release
// ============================================================================
module autosel_boot_seq
    import autosel_pkg::*;
#(
    parameter int          POR_DELAY    = 1000,
    parameter int          RETRY_DELAY  = 5000,
    parameter int          MAX_ATTEMPTS = 3,
    parameter int          READ_TIMEOUT = 200000,
    parameter logic [3:0]  MAGIC        = 4'hA,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          DEFAULT_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_ee_rst,
    output logic                  o_ee_start,
    input  logic                  i_ee_busy,
    input  logic                  i_ee_error,
    input  logic [15:0]           i_ee_data,
    input  logic                  i_rerun,
    output logic [ADDR_WIDTH-1:0] o_sel_addr,
    output logic                  o_sel_valid,
    input  logic                  i_sel_ready,
    output logic                  o_done,
    output logic                  o_fail,
    output logic [1:0]            o_attempts
);

    // The reader needs at least two reset cycles to clear cleanly.
    localparam int c_backoff_cyc = max_int(RETRY_DELAY, 2);
    localparam int c_cnt_max     = max_int(max_int(POR_DELAY, c_backoff_cyc),
                                           max_int(READ_TIMEOUT, START_SEEN_LIMIT));
    localparam int c_cnt_w       = $clog2(c_cnt_max + 1);
    localparam int c_fail_w      = max_int(2, $clog2(MAX_ATTEMPTS + 1));
    localparam logic [ADDR_WIDTH-1:0] c_default_addr = ADDR_WIDTH'(DEFAULT_ADDR);

    state_t                r_state;
    state_t                w_next;
    logic [c_cnt_w-1:0]    w_limit;
    logic                  w_expired;
    logic                  w_clear;
    logic                  w_pass;
    logic                  w_attempt_fail;
    logic                  w_retry;
    logic                  w_magic_ok;
    logic [c_fail_w-1:0]   r_fail_cnt;
    logic [c_fail_w-1:0]   w_fail_inc;
    logic [1:0]            w_att_sat;
    logic [1:0]            r_attempts;
    logic                  r_ee_rst;
    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_sel_addr;
    logic                  w_unused_data;

    assign w_unused_data = ^i_ee_data;
    assign w_magic_ok    = (i_ee_data[MAGIC_HI:MAGIC_LO] == MAGIC);
    assign w_fail_inc    = r_fail_cnt + c_fail_w'(1);
    assign w_att_sat     = (w_fail_inc > c_fail_w'(3)) ? 2'd3 : w_fail_inc[1:0];
    assign w_retry       = (w_fail_inc < c_fail_w'(MAX_ATTEMPTS));
    assign w_clear       = (w_next != r_state);

    always_comb begin
        w_limit = '0;
        case (r_state)
            POR:     w_limit = c_cnt_w'(POR_DELAY);
            START:   w_limit = c_cnt_w'(START_SEEN_LIMIT);
            WAIT:    w_limit = c_cnt_w'(READ_TIMEOUT);
            BACKOFF: w_limit = c_cnt_w'(c_backoff_cyc);
            default: w_limit = '0;
        endcase
    end

    autosel_delay_cnt #(
        .WIDTH (c_cnt_w)
    ) u_delay_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_limit   (w_limit),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= POR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_pass         = 1'b0;
        w_attempt_fail = 1'b0;
        o_ee_start     = 1'b0;
        o_sel_valid    = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            POR: begin
                if (w_expired) w_next = START;
            end
            START: begin
                o_ee_start = 1'b1;
                // Busy already high from an aborted transfer counts as seen.
                if (i_ee_busy)      w_next = WAIT;
                else if (w_expired) w_attempt_fail = 1'b1;
            end
            WAIT: begin
                // Error is sticky, so it is judged once the read has ended.
                if (!i_ee_busy)     w_next = CHECK;
                else if (w_expired) w_attempt_fail = 1'b1;
            end
            CHECK: begin
                if (!i_ee_error && w_magic_ok) begin
                    w_pass = 1'b1;
                    w_next = PUBLISH;
                end else begin
                    w_attempt_fail = 1'b1;
                end
            end
            BACKOFF: begin
                if (w_expired) w_next = START;
            end
            PUBLISH: begin
                o_sel_valid = 1'b1;
                if (i_sel_ready) w_next = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                if (i_rerun) w_next = BACKOFF;
            end
            default: w_next = POR;
        endcase
        if (w_attempt_fail) begin
            w_next = w_retry ? BACKOFF : PUBLISH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ee_rst   <= 1'b1;
            r_sel_addr <= c_default_addr;
            r_fail     <= 1'b0;
            r_fail_cnt <= '0;
            r_attempts <= 2'd0;
        end else begin
            // Registered from the next state so reset tracks BACKOFF exactly.
            r_ee_rst <= (w_next == POR) || (w_next == BACKOFF);
            if (w_pass) begin
                r_sel_addr <= i_ee_data[ADDR_WIDTH-1:0];
                r_attempts <= w_att_sat;
            end
            if (w_attempt_fail) begin
                r_fail_cnt <= w_fail_inc;
                r_attempts <= w_att_sat;
                if (!w_retry) begin
                    r_sel_addr <= c_default_addr;
                    r_fail     <= 1'b1;
                end
            end
            if ((r_state == DONE) && i_rerun) begin
                r_fail     <= 1'b0;
                r_fail_cnt <= '0;
                r_attempts <= 2'd0;
            end
        end
    end

    assign o_ee_rst   = r_ee_rst;
    assign o_sel_addr = r_sel_addr;
    assign o_fail     = r_fail;
    assign o_attempts = r_attempts;

endmodule
`default_nettype wire
